// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the iterative byte-substitution unit: input state, output state, busy.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Optional: SUB_BYTES_FWD_EN adds the mode signal (1 = forward S-box, 0 = inverse).
interface inv_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef SUB_BYTES_FWD_EN
    logic         mode;

    modport master (
        output in_valid, in_data, out_ready, mode,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, mode,
        output in_ready, out_valid, out_data, busy
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per cycle.
// Latency: out_valid rises 16/BYTES_PER_CYCLE edges after the input handshake edge.
// Backpressure: one state in flight; in_ready returns the cycle after the output handshake, out_data held while stalled.
// Optional: define SUB_BYTES_FWD_EN to add a mode input (1 = forward S-box, 0 = inverse) latched at accept.
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    inv_sub_bytes_seq_if.slave bus
);
    localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    // Reject chunk sizes that do not divide the state into whole power-of-two chunks.
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : gBadBpc
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Entry 0 sits at the MSB end, so INV_SBOX[x] is InvS(x).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

`ifdef SUB_BYTES_FWD_EN
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic modeQ;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] chunkCnt;
    logic [127:0]     work;
    logic [127:0]     nextWork;
    logic             inReadyQ;
    logic             outValidQ;
    logic             busyQ;
    logic [6:0]       chunkTop;
    logic [7:0]       laneIn  [BYTES_PER_CYCLE];
    logic [7:0]       laneOut [BYTES_PER_CYCLE];

    // Bit position of the first (most significant) byte of the current chunk.
    assign chunkTop = 7'd127 - 7'(int'(chunkCnt) * BYTES_PER_CYCLE * 8);

    // One table lookup per lane; lane 0 takes the lowest byte index of the chunk.
    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : gLane
        assign laneIn[j] = work[chunkTop - 7'(8 * j) -: 8];
`ifdef SUB_BYTES_FWD_EN
        assign laneOut[j] = modeQ ? FWD_SBOX[laneIn[j]] : INV_SBOX[laneIn[j]];
`else
        assign laneOut[j] = INV_SBOX[laneIn[j]];
`endif
    end

    // Merge the substituted chunk back into the untouched bytes of the work register.
    always_comb begin
        nextWork = work;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            nextWork[chunkTop - 7'(8 * j) -: 8] = laneOut[j];
        end
    end

    // Control FSM with registered handshake outputs; work register doubles as the output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chunkCnt  <= '0;
            work      <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
`ifdef SUB_BYTES_FWD_EN
            modeQ     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work     <= bus.in_data;
                        chunkCnt <= '0;
                        state    <= RUN;
                        inReadyQ <= 1'b0;
                        busyQ    <= 1'b1;
`ifdef SUB_BYTES_FWD_EN
                        modeQ    <= bus.mode;
`endif
                    end
                end
                RUN: begin
                    work <= nextWork;
                    if (chunkCnt == LAST_CHUNK) begin
                        chunkCnt  <= '0;
                        state     <= DONE;
                        outValidQ <= 1'b1;
                    end else begin
                        chunkCnt <= chunkCnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        outValidQ <= 1'b0;
                        inReadyQ  <= 1'b1;
                        busyQ     <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    chunkCnt  <= '0;
                    inReadyQ  <= 1'b1;
                    outValidQ <= 1'b0;
                    busyQ     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValidQ;
    assign bus.out_data  = work;
    assign bus.busy      = busyQ;
endmodule
